// File: rtl/fwd_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl_if
// Bundles the ID-stage instruction info and the pipeline control outputs
// exchanged between the pipeline datapath and the forwarding/hazard
// controller.
//   master : pipeline side  (drives ID info and br_taken, receives controls)
//   slave  : controller side (receives ID info, drives controls)
// Signals:
//   id_rs/id_rt/id_dst      REG_AW  source A/B and destination of ID instr
//   id_use_rs/id_use_rt     1       ID instruction reads rs/rt
//   id_reg_wr/id_mem_rd     1       ID instruction writes a reg / is a load
//   br_taken                1       branch resolved taken (kill IF/ID)
//   stall/bubble/flush      1       combinational pipeline controls
//   fwd_a_sel/fwd_b_sel     2       registered EX operand mux selects
//   stall_cnt               CNT_W   saturating stall-cycle counter
// ---------------------------------------------------------------------------
interface fwd_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_dst;
  logic              id_reg_wr;
  logic              id_mem_rd;
  logic              br_taken;
  logic              stall;
  logic              bubble;
  logic              flush;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_reg_wr, id_mem_rd,
           br_taken,
    input  stall, bubble, flush, fwd_a_sel, fwd_b_sel, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_reg_wr, id_mem_rd,
           br_taken,
    output stall, bubble, flush, fwd_a_sel, fwd_b_sel, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
// Forwarding and hazard controller for the 5-stage pipeline. Keeps a shadow
// copy of the destination info of the instructions in EX and MEM, detects
// RAW / load-use hazards against the instruction in ID, and drives the
// stall/bubble/flush controls plus the registered EX operand-mux selects
// (00 = regfile, 01 = EX/MEM ALU result, 10 = MEM/WB writeback data).
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high
//   bus   fwd_hazard_ctrl_if.slave (ID info in, pipeline controls out)
//
// Configuration macro:
//   FORWARDING_EN  defined   : forwarding selects active, only load-use stalls
//                  undefined : selects fixed at 00, any RAW dependency on an
//                              instruction in EX or MEM stalls
//
// The WB stage is not shadowed: the register file is write-before-read, so
// an instruction in WB can never cause a hazard or need a forward.
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  fwd_hazard_ctrl_if.slave   bus
);

  // Shadow of EX-stage instruction
  logic              ex_v_r;
  logic [REG_AW-1:0] ex_dst_r;
  logic              ex_wr_r;
  logic              ex_ld_r;
  // Shadow of MEM-stage instruction (load flag no longer relevant here)
  logic              mem_v_r;
  logic [REG_AW-1:0] mem_dst_r;
  logic              mem_wr_r;

  logic [1:0]        fwd_a_r;
  logic [1:0]        fwd_b_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  logic              hit_ex_a_s;
  logic              hit_ex_b_s;
  logic              hit_mem_a_s;
  logic              hit_mem_b_s;
  logic              ld_hz_s;
  logic              hz_s;
  logic              stall_s;
  logic              bubble_s;
  logic [1:0]        fwd_a_nxt_s;
  logic [1:0]        fwd_b_nxt_s;

  // A producer matches a consumer operand only if it really writes a
  // non-zero register and the consumer actually reads that operand.
  function automatic logic hit(
    input logic              v,
    input logic              wr,
    input logic [REG_AW-1:0] dst,
    input logic [REG_AW-1:0] r,
    input logic              use_r
  );
    return v & wr & (dst != {REG_AW{1'b0}}) & (dst == r) & use_r;
  endfunction

  // Hazard detection and combinational stall/bubble generation
  always_comb begin
    hit_ex_a_s  = hit(ex_v_r,  ex_wr_r,  ex_dst_r,  bus.id_rs, bus.id_use_rs);
    hit_ex_b_s  = hit(ex_v_r,  ex_wr_r,  ex_dst_r,  bus.id_rt, bus.id_use_rt);
    hit_mem_a_s = hit(mem_v_r, mem_wr_r, mem_dst_r, bus.id_rs, bus.id_use_rs);
    hit_mem_b_s = hit(mem_v_r, mem_wr_r, mem_dst_r, bus.id_rt, bus.id_use_rt);
    ld_hz_s     = ex_ld_r & (hit_ex_a_s | hit_ex_b_s);
`ifdef FORWARDING_EN
    hz_s        = ld_hz_s;
`else
    // ld_hz_s is a subset of the EX hits; kept in the OR for clarity.
    hz_s        = ld_hz_s | hit_ex_a_s | hit_ex_b_s | hit_mem_a_s | hit_mem_b_s;
`endif
    // A taken branch kills the ID instruction, so it can never stall.
    stall_s     = ~bus.br_taken & hz_s;
    bubble_s    = stall_s | bus.br_taken;
  end

  // Next forward selects: nearest producer (EX) wins over MEM
  always_comb begin
    fwd_a_nxt_s = 2'b00;
    fwd_b_nxt_s = 2'b00;
`ifdef FORWARDING_EN
    if (hit_ex_a_s) begin
      fwd_a_nxt_s = 2'b01;
    end else if (hit_mem_a_s) begin
      fwd_a_nxt_s = 2'b10;
    end else begin
      fwd_a_nxt_s = 2'b00;
    end
    if (hit_ex_b_s) begin
      fwd_b_nxt_s = 2'b01;
    end else if (hit_mem_b_s) begin
      fwd_b_nxt_s = 2'b10;
    end else begin
      fwd_b_nxt_s = 2'b00;
    end
`else
    fwd_a_nxt_s = 2'b00;
    fwd_b_nxt_s = 2'b00;
`endif
  end

  // Shadow pipeline advance; never frozen, a bubble inserts an invalid EX
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v_r    <= 1'b0;
      ex_dst_r  <= {REG_AW{1'b0}};
      ex_wr_r   <= 1'b0;
      ex_ld_r   <= 1'b0;
      mem_v_r   <= 1'b0;
      mem_dst_r <= {REG_AW{1'b0}};
      mem_wr_r  <= 1'b0;
    end else begin
      mem_v_r   <= ex_v_r;
      mem_dst_r <= ex_dst_r;
      mem_wr_r  <= ex_wr_r;
      ex_v_r    <= ~bubble_s;
      ex_dst_r  <= bus.id_dst;
      ex_wr_r   <= bus.id_reg_wr;
      ex_ld_r   <= bus.id_mem_rd;
    end
  end

  // Forward select registers, cleared when ID/EX is bubbled
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_r <= 2'b00;
      fwd_b_r <= 2'b00;
    end else if (bubble_s) begin
      fwd_a_r <= 2'b00;
      fwd_b_r <= 2'b00;
    end else begin
      fwd_a_r <= fwd_a_nxt_s;
      fwd_b_r <= fwd_b_nxt_s;
    end
  end

  // Saturating stall-cycle performance counter
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && !(&stall_cnt_r)) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.stall     = stall_s;
  assign bus.bubble    = bubble_s;
  assign bus.flush     = bus.br_taken;
  assign bus.fwd_a_sel = fwd_a_r;
  assign bus.fwd_b_sel = fwd_b_r;
  assign bus.stall_cnt = stall_cnt_r;

endmodule
